// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: rebuilds column/row from pin-level HSync/VSync, checks line and
// frame totals against the expected raster, and gates RGB with the active window once locked.
module vga_sync_receiver #(
  parameter int   TOTAL_COLS    = 800,
  parameter int   TOTAL_ROWS    = 525,
  parameter int   ACTIVE_COLS   = 640,
  parameter int   ACTIVE_ROWS   = 480,
  parameter int   H_FRONT_PORCH = 16,
  parameter int   V_FRONT_PORCH = 10,
  parameter logic SYNC_POL      = 1'b0,
  parameter int   LOCK_FRAMES   = 2
) (
  input  logic       CLK,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [2:0] i_Red,
  input  logic [2:0] i_Green,
  input  logic [2:0] i_Blue,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row,
  output logic       o_Active,
  output logic [2:0] o_Red,
  output logic [2:0] o_Green,
  output logic [2:0] o_Blue,
  output logic       o_Locked,
  output logic       o_Err,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [9:0]  H_START      = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0]  V_START      = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0]  COL_LAST     = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST     = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]  ROW_TOTAL    = 10'(TOTAL_ROWS);
  localparam logic [9:0]  ACT_COLS     = 10'(ACTIVE_COLS);
  localparam logic [9:0]  ACT_ROWS     = 10'(ACTIVE_ROWS);
  localparam logic [10:0] LINE_GOOD    = 11'(TOTAL_COLS - 1);
  localparam logic [10:0] TIMEOUT_LAST = 11'(2 * TOTAL_COLS - 1);
  localparam logic [10:0] LINE_SAT     = 11'h7FF;
  localparam logic [9:0]  FRAME_SAT    = 10'h3FF;
  localparam logic [2:0]  LOCK_TARGET  = 3'(LOCK_FRAMES);

  // There is no handshake: the outputs form a stream that is valid on every clock,
  // one cycle behind the inputs; downstream qualifies pixels with o_Active only.

  state_t      state;
  logic        prev_h;
  logic        prev_v;
  logic        h_seen;
  logic [10:0] line_cnt;
  logic [9:0]  frame_cnt;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [2:0]  good_cnt;
  logic [8:0]  rgb_q;
  logic        err;

  logic h_edge;
  logic v_edge;
  logic col_wrap;
  logic line_bad;
  logic timeout;
  logic frame_eval;
  logic frame_bad;
  logic frame_good;

  assign h_edge     = (i_HSync == SYNC_POL) && (prev_h != SYNC_POL);
  assign v_edge     = (i_VSync == SYNC_POL) && (prev_v != SYNC_POL);
  assign col_wrap   = !h_edge && (col == COL_LAST);
  // line_cnt holds (cycles since the last H edge) - 1, so a good line ends at TOTAL_COLS-1.
  assign line_bad   = h_edge && h_seen && (line_cnt != LINE_GOOD);
  assign timeout    = !h_edge && (line_cnt == TIMEOUT_LAST);
  assign frame_eval = v_edge && (state != UNLOCKED);
  assign frame_bad  = frame_eval && (frame_cnt != ROW_TOTAL);
  assign frame_good = frame_eval && (frame_cnt == ROW_TOTAL);

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      prev_h <= SYNC_POL;
      prev_v <= SYNC_POL;
      col    <= '0;
      row    <= '0;
      rgb_q  <= '0;
    end else begin
      prev_h <= i_HSync;
      prev_v <= i_VSync;
      rgb_q  <= {i_Red, i_Green, i_Blue};
      if (h_edge)        col <= H_START;
      else if (col_wrap) col <= '0;
      else               col <= col + 10'd1;
      if (v_edge)        row <= V_START;
      else if (col_wrap) row <= (row == ROW_LAST) ? 10'd0 : row + 10'd1;
    end
  end

  // After a timeout the next H edge only restarts line timing; it is not judged.
  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      line_cnt  <= '0;
      h_seen    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (h_edge) begin
        line_cnt <= '0;
        h_seen   <= 1'b1;
      end else if (timeout) begin
        line_cnt <= LINE_SAT;
        h_seen   <= 1'b0;
      end else if (line_cnt != LINE_SAT) begin
        line_cnt <= line_cnt + 11'd1;
      end
      if (v_edge)                              frame_cnt <= h_edge ? 10'd1 : 10'd0;
      else if (h_edge && frame_cnt != FRAME_SAT) frame_cnt <= frame_cnt + 10'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_Reset) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= line_bad || frame_bad || timeout;
      if (timeout) begin
        state    <= UNLOCKED;
        good_cnt <= '0;
      end else begin
        case (state)
          UNLOCKED: begin
            if (v_edge) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          ACQUIRE: begin
            if (line_bad || frame_bad) begin
              good_cnt <= '0;
            end else if (frame_good) begin
              if ((good_cnt + 3'd1) >= LOCK_TARGET) begin
                state    <= LOCKED;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + 3'd1;
              end
            end
          end
          LOCKED: begin
            if (line_bad || frame_bad) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end
          default: begin
            state    <= UNLOCKED;
            good_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_Col    = col;
  assign o_Row    = row;
  assign o_Locked = (state == LOCKED);
  assign o_Active = o_Locked && (col < ACT_COLS) && (row < ACT_ROWS);
  assign o_Red    = o_Active ? rgb_q[8:6] : 3'd0;
  assign o_Green  = o_Active ? rgb_q[5:3] : 3'd0;
  assign o_Blue   = o_Active ? rgb_q[2:0] : 3'd0;
  assign o_Err    = err;
  assign o_State  = state;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster: a sync generator drives the DUT, a
// timestamp-based reference model queues expected outputs, and a monitor compares each cycle.
module tb_vga_sync_receiver;

  localparam int   TC    = 40;
  localparam int   TR    = 20;
  localparam int   AC    = 32;
  localparam int   AR    = 15;
  localparam int   HFP   = 2;
  localparam int   VFP   = 1;
  localparam int   LF    = 2;
  localparam logic SP    = 1'b0;
  localparam int   HW    = 4;
  localparam int   VW    = 2;
  localparam int   HS    = AC + HFP;
  localparam int   VS    = AR + VFP;
  localparam int   FRAME = TC * TR;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync, vsync;
  logic [2:0] red, green, blue;
  logic [9:0] o_col, o_row;
  logic       o_active, o_locked, o_err;
  logic [2:0] o_red, o_green, o_blue;
  logic [1:0] o_state;

  vga_sync_receiver #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .V_FRONT_PORCH(VFP), .SYNC_POL(SP), .LOCK_FRAMES(LF)
  ) dut (
    .CLK(clk), .i_Reset(rst), .i_HSync(hsync), .i_VSync(vsync),
    .i_Red(red), .i_Green(green), .i_Blue(blue),
    .o_Col(o_col), .o_Row(o_row), .o_Active(o_active),
    .o_Red(o_red), .o_Green(o_green), .o_Blue(o_blue),
    .o_Locked(o_locked), .o_Err(o_err), .o_State(o_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  int checks = 0;
  int passed = 0;
  int err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("col",    {22'd0, o_col},                     {22'd0, mon_e[31:22]});
      check("row",    {22'd0, o_row},                     {22'd0, mon_e[21:12]});
      check("active", {31'd0, o_active},                  {31'd0, mon_e[11]});
      check("rgb",    {23'd0, o_red, o_green, o_blue},    {23'd0, mon_e[10:2]});
      check("locked", {31'd0, o_locked},                  {31'd0, mon_e[1]});
      check("err",    {31'd0, o_err},                     {31'd0, mon_e[0]});
      if (o_err) err_seen++;
    end
  end

  // reference model: line timing from H-edge timestamps, frame timing from H edges per V interval
  int         m_cyc = 0, m_last_h = 0, m_col = 0, m_row = 0, m_hcount = 0, m_good = 0;
  bit         m_prev_h, m_prev_v, m_h_seen, m_tracking, m_locked, m_err;
  logic [8:0] m_rgb;

  task automatic model_step(input bit rs, input logic hh, input logic vv, input logic [8:0] px);
    bit he, ve, wrap, bad_line, bad_frame, good_frame, tmo, act;
    int since;
    if (rs) begin
      m_prev_h = SP; m_prev_v = SP; m_col = 0; m_row = 0; m_last_h = m_cyc;
      m_h_seen = 0; m_hcount = 0; m_tracking = 0; m_locked = 0; m_good = 0;
      m_rgb = '0; m_err = 0;
    end else begin
      he         = (hh == SP) && (m_prev_h != SP);
      ve         = (vv == SP) && (m_prev_v != SP);
      since      = m_cyc - m_last_h;
      bad_line   = he && m_h_seen && (since != TC);
      tmo        = !he && (since == 2 * TC);
      good_frame = ve && m_tracking && (m_hcount == TR);
      bad_frame  = ve && m_tracking && (m_hcount != TR);
      wrap       = !he && (m_col == TC - 1);
      m_col      = he ? HS : (m_col + 1) % TC;
      if (ve) m_row = VS;
      else if (wrap) m_row = (m_row + 1) % TR;
      if (he) begin m_last_h = m_cyc; m_h_seen = 1; end
      if (tmo) m_h_seen = 0;
      if (ve) m_hcount = he ? 1 : 0;
      else if (he) m_hcount++;
      if (tmo) begin
        m_tracking = 0; m_locked = 0; m_good = 0;
      end else if (!m_tracking) begin
        if (ve) begin m_tracking = 1; m_good = 0; end
      end else if (bad_line || bad_frame) begin
        m_locked = 0; m_good = 0;
      end else if (good_frame && !m_locked) begin
        m_good++;
        if (m_good >= LF) m_locked = 1;
      end
      m_err = bad_line || bad_frame || tmo;
      m_rgb = px; m_prev_h = hh; m_prev_v = vv;
    end
    m_cyc++;
    act = m_locked && (m_col < AC) && (m_row < AR);
    exp_q.push_back({10'(m_col), 10'(m_row), act, act ? m_rgb : 9'd0, m_locked, m_err});
  endtask

  // sync generator and driver tasks
  int         g_col = 0, g_row = 0, g_hoff = 0, g_short_row = 0;
  bit         g_short_line = 0, g_short_frame = 0, g_short_frame_arm = 0, g_hoff_arm = 0;
  logic [8:0] last_px;

  task automatic gen_advance();
    int line_end;
    line_end = (g_short_line && g_row == g_short_row) ? TC - 2 : TC - 1;
    if (g_hoff > 0) g_hoff--;
    if (g_col >= line_end) begin
      if (line_end == TC - 2) g_short_line = 0;
      g_col = 0;
      if (g_row >= (g_short_frame ? TR - 2 : TR - 1)) begin
        g_row = 0;
        g_short_frame = g_short_frame_arm;
        g_short_frame_arm = 0;
      end else begin
        g_row++;
      end
    end else begin
      g_col++;
    end
    if (g_hoff_arm && g_col == 0 && g_row == 2) begin
      g_hoff = 2 * TC;
      g_hoff_arm = 0;
    end
  endtask

  task automatic gen_step(input bit rst_in);
    logic hh, vv;
    logic [8:0] px;
    hh = (g_col >= HS && g_col < HS + HW && g_hoff == 0) ? SP : ~SP;
    vv = (g_row >= VS && g_row < VS + VW) ? SP : ~SP;
    px = 9'($urandom_range(0, 511));
    rst = rst_in; hsync = hh; vsync = vv;
    {red, green, blue} = px;
    last_px = px;
    @(posedge clk);
    model_step(rst_in, hh, vv, px);
    @(negedge clk);
    #1;
    gen_advance();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) gen_step(1'b0);
  endtask

  task automatic step_until(input int col, input int row);
    int n;
    n = 0;
    while (!(g_col == col && (row < 0 || g_row == row)) && n < FRAME + TC) begin
      gen_step(1'b0);
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_col"},    {22'd0, o_col}, 32'd0);
    check({tag, "_row"},    {22'd0, o_row}, 32'd0);
    check({tag, "_active"}, {31'd0, o_active}, 32'd0);
    check({tag, "_rgb"},    {23'd0, o_red, o_green, o_blue}, 32'd0);
    check({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
    check({tag, "_err"},    {31'd0, o_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; hsync = ~SP; vsync = ~SP; red = '0; green = '0; blue = '0; last_px = '0;

    // power-on reset, then nominal raster until locked
    repeat (3) gen_step(1'b1);
    check_all_zero("reset");
    err_seen = 0;
    run_cycles(4 * FRAME);
    check("nominal_err_pulses", err_seen, 0);
    check("nominal_locked", {31'd0, o_locked}, 32'd1);

    // H edge reload and first active pixel
    step_until(HS, -1);
    gen_step(1'b0);
    check("hedge_col", {22'd0, o_col}, HS);
    step_until(0, 0);
    gen_step(1'b0);
    check("first_px_col", {22'd0, o_col}, 32'd0);
    check("first_px_row", {22'd0, o_row}, 32'd0);
    check("first_px_active", {31'd0, o_active}, 32'd1);
    check("first_px_rgb", {23'd0, o_red, o_green, o_blue}, {23'd0, last_px});

    // one line a clock short
    err_seen = 0;
    g_short_row = $urandom_range(1, TR - 3);
    g_short_line = 1;
    run_cycles(4 * FRAME);
    check("short_line_err_pulses", err_seen, 1);
    check("short_line_relocked", {31'd0, o_locked}, 32'd1);

    // one frame a line short
    err_seen = 0;
    g_short_frame_arm = 1;
    run_cycles(5 * FRAME);
    check("short_frame_err_pulses", err_seen, 1);
    check("short_frame_relocked", {31'd0, o_locked}, 32'd1);

    // HSync missing for two line periods
    err_seen = 0;
    g_hoff_arm = 1;
    run_cycles(5 * FRAME);
    check("timeout_err_pulses", err_seen, 1);
    check("timeout_relocked", {31'd0, o_locked}, 32'd1);

    // reset mid-line while HSync is asserted; no edge on release
    step_until(HS + 1, -1);
    gen_step(1'b1);
    check_all_zero("midreset");
    err_seen = 0;
    gen_step(1'b0);
    check("midreset_no_hedge_col", {22'd0, o_col}, 32'd1);
    check("midreset_row", {22'd0, o_row}, 32'd0);
    run_cycles(5 * FRAME);
    check("midreset_err_pulses", err_seen, 0);
    check("midreset_relocked", {31'd0, o_locked}, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive end of the VGA sync interface: consumes pin-level HSync/VSync plus 3-bit-per-channel RGB, as driven by the board's VGA generator chain, and reconstructs column/row position.
- Checks incoming timing against expected line and frame totals, declares lock after consecutive good frames, and emits position, active-video flag and gated RGB.
- Used for on-board loopback checking of the VGA output path and as the front end for downstream capture/overlay logic.

Parameters:
- TOTAL_COLS, 800, clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- H_FRONT_PORCH, 16, columns between last active column and HSync assertion
- V_FRONT_PORCH, 10, rows between last active row and VSync assertion
- SYNC_POL, 0, asserted level of both sync inputs (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..7)

Ports:
- CLK  in  1  pixel clock; all logic on rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_HSync  in  1  horizontal sync, same clock domain
- i_VSync  in  1  vertical sync, same clock domain
- i_Red, i_Green, i_Blue  in  3 each  pixel data, aligned with syncs
- o_Col  out  10  reconstructed column, 0 = first active pixel
- o_Row  out  10  reconstructed row, 0 = first active line
- o_Active  out  1  high when locked and o_Col<ACTIVE_COLS and o_Row<ACTIVE_ROWS
- o_Red, o_Green, o_Blue  out  3 each  input RGB delayed 1 cycle, forced 0 when o_Active=0
- o_Locked  out  1  timing lock
- o_Err  out  1  single-cycle pulse on bad line, bad frame or timeout

Behaviour:
- Reset: all outputs 0; FSM UNLOCKED; all counters 0; previous-sync registers loaded with the asserted level (SYNC_POL), so a sync held asserted through reset produces no edge.
- Edge detect: an H edge is a cycle with i_HSync==SYNC_POL and previous sample !=SYNC_POL. V edge is the same for i_VSync.
- Position: all outputs are registered with 1-cycle latency.
  - H edge at cycle n: o_Col=ACTIVE_COLS+H_FRONT_PORCH (656) at n+1.
  - Otherwise o_Col increments, wrapping from TOTAL_COLS-1 to 0. Each wrap increments o_Row, wrapping from TOTAL_ROWS-1 to 0.
  - V edge: o_Row=ACTIVE_ROWS+V_FRONT_PORCH (490) at n+1, overriding any wrap increment in the same cycle.
  - Simultaneous H and V edges apply both loads.
- Line check:
  - An 11-bit counter, saturating at 2047, counts cycles since the last H edge.
  - At each H edge after the first since reset, the line is good if count+1==TOTAL_COLS; otherwise it is bad.
  - Timeout: the counter reaching 2*TOTAL_COLS without an H edge.
- Frame check:
  - A 10-bit counter counts H edges since the last V edge. A V edge evaluates it, then reloads it to 1 if an H edge coincides, else 0.
  - The frame is good if the count==TOTAL_ROWS.
  - The first V edge after reset or UNLOCKED entry is not evaluated.
- FSM:
  - UNLOCKED -> ACQUIRE on first V edge; good-frame count cleared.
  - ACQUIRE: a good frame increments the good count; reaching LOCK_FRAMES -> LOCKED, with o_Locked=1 on the next cycle.
  - ACQUIRE: a bad line or bad frame clears the good count and stays in ACQUIRE.
  - LOCKED: a bad line or bad frame -> ACQUIRE; good count cleared; o_Locked=0 on the next cycle.
  - Any state: timeout -> UNLOCKED, o_Locked=0, line counter held saturated until the next H edge.
  - o_Err pulses 1 cycle (cycle after detection) for each bad line, bad frame or timeout event. Coincident events give one pulse.
- Position counters free-run in all states; only o_Active and RGB gating depend on lock.
- Reset asserted mid-frame returns everything to reset values on the next edge; relock requires a fresh UNLOCKED -> ACQUIRE -> LOCKED sequence.

Test Plan:
- Reset with nominal 640x480 generator: first V edge enters ACQUIRE; o_Locked rises the cycle after the 2nd good-frame V edge; o_Err never pulses.
- After lock, sample at the H edge: o_Col=656 the next cycle. At the first active pixel of row 0: o_Col=0, o_Row=0, o_Active=1, o_Red/Green/Blue equal the inputs of the previous cycle.
- While locked, shorten one line to 799 clocks: o_Err pulses once; o_Locked drops the next cycle; relock after 2 further good frames.
- Frame with 524 lines: bad frame at the V edge; o_Err pulse; o_Locked low; RGB outputs forced to 0 until relock.
- Hold i_HSync deasserted for 1600 clocks: timeout, FSM UNLOCKED, single o_Err pulse. On restoring sync, lock returns after first V edge plus 2 good frames.
- Assert i_Reset mid-line while locked: next cycle all outputs 0. Sync held asserted across reset release produces no H edge until it deasserts and reasserts.
